// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix unary-operation unit:
// op encodings, FSM states and the saturation helper.
package matriz_pkg;

  localparam logic [1:0] OP_NEG     = 2'b00;
  localparam logic [1:0] OP_TRANSP  = 2'b01;
  localparam logic [1:0] OP_ESCALAR = 2'b10;
  localparam logic [1:0] OP_COPIA   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } estado_t;

  // Clamp a wide signed value to a w-bit signed range.
  // Bit 64 of the result flags that clamping happened.
  function automatic logic [64:0] saturar(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (v > mx) begin
      return {1'b1, mx};
    end else if (v < mn) begin
      return {1'b1, mn};
    end else begin
      return {1'b0, v};
    end
  endfunction

endpackage

// File: rtl/op_unaria_matriz_elemento_alu.sv
// Combinational per-element operator: negate, scale or pass,
// with saturation to W bits.
module elemento_alu
  import matriz_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] escalar,
  input  logic [1:0]   op,
  output logic [W-1:0] y,
  output logic         sat
);

  logic signed [W-1:0]   xv;
  logic signed [W-1:0]   ev;
  logic signed [2*W-1:0] prod;
  logic signed [63:0]    xs;
  logic [64:0]           r;
  logic                  unused_bits;

  assign xv   = x;
  assign ev   = escalar;
  assign xs   = 64'(xv);
  assign prod = (2*W)'(xv) * (2*W)'(ev);

  always_comb begin
    r = {1'b0, xs};
    unique case (1'b1)
      (op == OP_NEG):     r = saturar(-xs, W);
      (op == OP_ESCALAR): r = saturar(64'(prod), W);
      default:            r = {1'b0, xs};
    endcase
  end

  assign y           = r[W-1:0];
  assign sat         = r[64];
  assign unused_bits = ^r[63:W];

endmodule

// File: rtl/op_unaria_matriz.sv
// Matrix unary-operation unit: captures an NxN matrix on start
// and writes one saturated result row per cycle.
module op_unaria_matriz
  import matriz_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [W-1:0]     escalar,
  input  logic [N*N*W-1:0] matriz_A,
  output logic [N*N*W-1:0] resultado,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int FW = $clog2(N);

  estado_t          state_q, state_d;
  logic [FW-1:0]    fila_q, fila_d;
  logic [N*N*W-1:0] a_q;
  logic [1:0]       op_q;
  logic [W-1:0]     esc_q;
  logic [N*N*W-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             cap;

  logic [N*W-1:0]   row_x;
  logic [N*W-1:0]   row_y;
  logic [N-1:0]     row_sat;

  // Transpose reads column r instead of row r.
  for (genvar j = 0; j < N; j++) begin : g_col
    assign row_x[j*W +: W] = (op_q == OP_TRANSP)
      ? a_q[(j*N + int'(fila_q))*W +: W]
      : a_q[(int'(fila_q)*N + j)*W +: W];

    elemento_alu #(.W(W)) u_alu (
      .x       (row_x[j*W +: W]),
      .escalar (esc_q),
      .op      (op_q),
      .y       (row_y[j*W +: W]),
      .sat     (row_sat[j])
    );
  end

  always_comb begin
    state_d = state_q;
    fila_d  = fila_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          ovf_d   = 1'b0;
          fila_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[int'(fila_q)*N*W +: N*W] = row_y;
        ovf_d = ovf_q | (|row_sat);
        if (fila_q == FW'(N - 1)) begin
          fila_d  = '0;
          state_d = DONE;
        end else begin
          fila_d = fila_q + FW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fila_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      op_q    <= OP_NEG;
      esc_q   <= '0;
    end else begin
      state_q <= state_d;
      fila_q  <= fila_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      if (cap) begin
        a_q   <= matriz_A;
        op_q  <= op;
        esc_q <= escalar;
      end
    end
  end

  assign resultado = res_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;

endmodule
